// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory and I/O responder on the CPU byte bus.
// Holds the byte RAM, UART RX/TX FIFOs, a free-running cycle counter with a
// coherent snapshot register, and the sticky program-stop flag.
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-low reset
//   cpu_a         byte address from core ([17:0] decoded)
//   cpu_wr        1 = write, 0 = read
//   cpu_dout      write data from core
//   cpu_din       registered read data to core (1-cycle latency)
//   rdy_o         core may issue an access (TX FIFO not full)
//   rx_data/rx_valid/rx_ready   UART receive stream into the RX FIFO
//   tx_data/tx_valid/tx_ready   UART transmit stream out of the TX FIFO
//   program_done  sticky stop flag
module cpu_bus_responder #(
    parameter int unsigned RAM_AW     = 17,
    parameter int unsigned FIFO_DEPTH = 8,
    // Counter reset value; nonzero only to exercise wrap-around quickly.
    parameter logic [31:0] CNT_RESET  = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        rdy_o,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_done
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [7:0]    r_ram [2**RAM_AW];
    logic [7:0]    r_ram_rd;
    logic          r_din_ram;   // cpu_din sources the RAM read register
    logic [7:0]    r_io_rd;
    logic [31:0]   r_cnt;
    logic [31:0]   r_snap;
    logic          r_done;

    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_rx_cnt;
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp;
    logic [CW-1:0] r_tx_cnt;

    logic          w_take, w_is_io, w_sel_uart, w_sel_cnt, w_stop_wr;
    logic [15:0]   w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic          w_rx_push, w_rx_pop, w_tx_push_uart, w_tx_push, w_tx_pop;
    logic [7:0]    w_tx_wdata, w_io_rdata;
    logic          w_unused_a;

    assign w_unused_a = ^cpu_a[31:18];

    assign rdy_o        = (r_tx_cnt != FULL);
    assign rx_ready     = (r_rx_cnt != FULL);
    assign tx_valid     = (r_tx_cnt != '0);
    assign tx_data      = r_tx_mem[r_tx_rp];
    assign program_done = r_done;
    assign cpu_din      = r_din_ram ? r_ram_rd : r_io_rd;

    // Address decode
    assign w_take     = rst_in && rdy_o;
    assign w_is_io    = (cpu_a[17:16] == 2'b11);
    assign w_off      = cpu_a[15:0];
    assign w_ram_idx  = cpu_a[RAM_AW-1:0];
    assign w_sel_uart = w_is_io && (w_off == 16'h0000);
    assign w_sel_cnt  = w_is_io && (w_off[15:2] == 14'h0001);
    assign w_stop_wr  = w_take && w_sel_cnt && cpu_wr && (w_off[1:0] == 2'd0);

    // FIFO handshakes
    assign w_rx_push      = rx_valid && rx_ready;
    assign w_rx_pop       = w_take && w_sel_uart && !cpu_wr && (r_rx_cnt != '0);
    assign w_tx_push_uart = w_take && w_sel_uart && cpu_wr && (cpu_dout != 8'h00);
    // The stop write queues a single 0x00 terminator, only on the first stop.
    assign w_tx_push      = w_tx_push_uart || (w_stop_wr && !r_done);
    assign w_tx_wdata     = w_tx_push_uart ? cpu_dout : 8'h00;
    assign w_tx_pop       = tx_valid && tx_ready;

    always_comb begin
        w_io_rdata = 8'h00;
        if (w_sel_uart) begin
            w_io_rdata = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rp] : 8'h00;
        end else if (w_sel_cnt) begin
            unique case (w_off[1:0])
                2'd0: w_io_rdata = r_cnt[7:0];
                2'd1: w_io_rdata = r_snap[15:8];
                2'd2: w_io_rdata = r_snap[23:16];
                2'd3: w_io_rdata = r_snap[31:24];
                default: w_io_rdata = 8'h00;
            endcase
        end
    end

    // RAM has no reset; w_take already excludes the reset cycle.
    always_ff @(posedge clk_in) begin
        if (w_take && !w_is_io) begin
            if (cpu_wr) begin
                r_ram[w_ram_idx] <= cpu_dout;
            end else begin
                r_ram_rd <= r_ram[w_ram_idx];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_din_ram <= 1'b0;
            r_io_rd   <= 8'h00;
            r_cnt     <= CNT_RESET;
            r_snap    <= 32'h0;
            r_done    <= 1'b0;
            r_rx_wp   <= '0;
            r_rx_rp   <= '0;
            r_rx_cnt  <= '0;
            r_tx_wp   <= '0;
            r_tx_rp   <= '0;
            r_tx_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;

            if (w_take) begin
                r_din_ram <= !w_is_io && !cpu_wr;
                r_io_rd   <= (w_is_io && !cpu_wr) ? w_io_rdata : 8'h00;
                // Byte-0 read freezes the full count so bytes 1..3 stay coherent.
                if (w_sel_cnt && !cpu_wr && (w_off[1:0] == 2'd0)) begin
                    r_snap <= r_cnt;
                end
                if (w_stop_wr) begin
                    r_done <= 1'b1;
                end
            end

            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= rx_data;
                r_rx_wp           <= r_rx_wp + PW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + PW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase

            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= w_tx_wdata;
                r_tx_wp           <= r_tx_wp + PW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + PW'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed testbench for cpu_bus_responder: table-driven RAM/decode vectors
// plus hand-written sequences for FIFOs, counter, stop flag and reset.
module tb_cpu_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        rdy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_done;

    // Second instance with the counter starting near wrap-around
    logic [31:0] b2_a;
    logic [7:0]  b2_din;
    logic        b2_rdy, b2_rx_ready, b2_tx_valid, b2_done;
    logic [7:0]  b2_tx_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_bus_responder u_dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .cpu_a        (cpu_a),
        .cpu_wr       (cpu_wr),
        .cpu_dout     (cpu_dout),
        .cpu_din      (cpu_din),
        .rdy_o        (rdy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .program_done (program_done)
    );

    cpu_bus_responder #(
        .CNT_RESET (32'hFFFF_FFFD)
    ) u_wrap (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .cpu_a        (b2_a),
        .cpu_wr       (1'b0),
        .cpu_dout     (8'h00),
        .cpu_din      (b2_din),
        .rdy_o        (b2_rdy),
        .rx_data      (8'h00),
        .rx_valid     (1'b0),
        .rx_ready     (b2_rx_ready),
        .tx_data      (b2_tx_data),
        .tx_valid     (b2_tx_valid),
        .tx_ready     (1'b0),
        .program_done (b2_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One bus access sampled at the next edge; bus returns to an idle RAM read.
    task automatic bus_op(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
        tick();
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic bus2_rd(input logic [31:0] a);
        b2_a = a;
        tick();
        b2_a = 32'h0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[1] = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00};
        vecs[2] = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vecs[3] = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C};
        vecs[4] = '{32'h0002_0123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vecs[5] = '{32'h0003_0001, 1'b1, 8'h11, 1'b0, 8'h00};
        vecs[6] = '{32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[7] = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[8] = '{32'h0000_0123, 1'b1, 8'h5B, 1'b0, 8'h00};
        vecs[9] = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'h5B};

        rst_n    = 1'b0;
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        b2_a     = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_cpu_din", cpu_din, 8'h00);
        check("rst_done", program_done, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_rdy", rdy, 1'b1);
        rst_n = 1'b1;

        // Wrap instance: edges 1..6 after reset
        bus2_rd(32'h0003_0004);
        check("wrap_b0", b2_din, 8'hFD);
        bus2_rd(32'h0003_0005);
        check("wrap_b1", b2_din, 8'hFF);
        bus2_rd(32'h0003_0006);
        check("wrap_b2", b2_din, 8'hFF);
        bus2_rd(32'h0003_0007);
        check("wrap_b3", b2_din, 8'hFF);
        bus2_rd(32'h0003_0004);
        check("wrap_after_b0", b2_din, 8'h01);
        bus2_rd(32'h0003_0007);
        check("wrap_after_b3", b2_din, 8'h00);

        // Main counter: byte-0 read sampled at edge 100 after reset
        repeat (93) tick();
        bus_op(32'h0003_0004, 1'b0, 8'h00);
        check("cnt_b0", cpu_din, 8'h63);
        bus_op(32'h0003_0005, 1'b0, 8'h00);
        check("cnt_b1", cpu_din, 8'h00);
        bus_op(32'h0003_0006, 1'b0, 8'h00);
        check("cnt_b2", cpu_din, 8'h00);
        bus_op(32'h0003_0007, 1'b0, 8'h00);
        check("cnt_b3", cpu_din, 8'h00);
        repeat (200) tick();
        // Snapshot must still hold 99 although the live count is now 303
        bus_op(32'h0003_0005, 1'b0, 8'h00);
        check("snap_stale_b1", cpu_din, 8'h00);
        bus_op(32'h0003_0004, 1'b0, 8'h00);
        check("cnt305_b0", cpu_din, 8'h30);
        bus_op(32'h0003_0005, 1'b0, 8'h00);
        check("cnt305_b1", cpu_din, 8'h01);

        // RAM and decode vectors
        for (int i = 0; i < 10; i++) begin
            bus_op(vecs[i].addr, vecs[i].wr, vecs[i].dout);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_din", i), cpu_din, vecs[i].exp);
            end
        end

        // RX basic
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        tick();
        rx_data  = 8'h42;
        tick();
        rx_valid = 1'b0;
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        check("rx_pop0", cpu_din, 8'h41);
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        check("rx_pop1", cpu_din, 8'h42);
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        check("rx_empty", cpu_din, 8'h00);

        // RX full
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h10 + 8'(i);
            tick();
        end
        check("rx_full_ready", rx_ready, 1'b0);
        rx_data = 8'h99;
        tick();
        tick();
        rx_valid = 1'b0;
        check("rx_full_hold", rx_ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus_op(32'h0003_0000, 1'b0, 8'h00);
            check($sformatf("rx_fill%0d", i), cpu_din, 8'h10 + 8'(i));
        end
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        check("rx_9th_dropped", cpu_din, 8'h00);

        // RX simultaneous push and pop
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick();
        rx_data  = 8'h66;
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx_pp_pop", cpu_din, 8'h55);
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        check("rx_pp_next", cpu_din, 8'h66);
        bus_op(32'h0003_0000, 1'b0, 8'h00);
        check("rx_pp_empty", cpu_din, 8'h00);

        // TX zero filter and backpressure
        bus_op(32'h0003_0000, 1'b1, 8'h00);
        check("tx_zero_filter", tx_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus_op(32'h0003_0000, 1'b1, 8'h81 + 8'(i));
            if (i == 6) begin
                check("tx_rdy_at7", rdy, 1'b1);
            end
        end
        check("tx_full_rdy", rdy, 1'b0);
        cpu_a    = 32'h0003_0000;
        cpu_wr   = 1'b1;
        cpu_dout = 8'h99;
        repeat (3) tick();
        check("tx_stall_rdy", rdy, 1'b0);
        check("tx_stall_head", tx_data, 8'h81);
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_drain%0d_valid", i), tx_valid, 1'b1);
            check($sformatf("tx_drain%0d_data", i), tx_data, 8'h81 + 8'(i));
            if (i == 0) begin
                check("tx_rdy_before_pop", rdy, 1'b0);
            end
            if (i == 1) begin
                check("tx_rdy_after_pop", rdy, 1'b1);
            end
            tick();
        end
        check("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Stop flag
        bus_op(32'h0003_0004, 1'b1, 8'h77);
        check("stop_done", program_done, 1'b1);
        check("stop_tx_valid", tx_valid, 1'b1);
        check("stop_tx_zero", tx_data, 8'h00);
        bus_op(32'h0003_0004, 1'b1, 8'h12);
        check("stop2_done", program_done, 1'b1);
        tx_ready = 1'b1;
        check("stop2_valid", tx_valid, 1'b1);
        tick();
        check("stop_single_byte", tx_valid, 1'b0);

        // TX simultaneous push and pop (tx_ready still 1)
        bus_op(32'h0003_0000, 1'b1, 8'h31);
        check("tx_pp0_valid", tx_valid, 1'b1);
        check("tx_pp0_data", tx_data, 8'h31);
        bus_op(32'h0003_0000, 1'b1, 8'h32);
        check("tx_pp1_valid", tx_valid, 1'b1);
        check("tx_pp1_data", tx_data, 8'h32);
        tick();
        check("tx_pp_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Reset mid-burst
        bus_op(32'h0003_0000, 1'b1, 8'hA1);
        bus_op(32'h0003_0000, 1'b1, 8'hA2);
        bus_op(32'h0003_0000, 1'b1, 8'hA3);
        bus_op(32'h0000_0123, 1'b0, 8'h00);
        check("pre_rst_din", cpu_din, 8'h5B);
        rst_n    = 1'b0;
        cpu_a    = 32'h0000_0123;
        cpu_wr   = 1'b1;
        cpu_dout = 8'hEE;
        tick();
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_din", cpu_din, 8'h00);
        check("mid_rst_done", program_done, 1'b0);
        check("mid_rst_rdy", rdy, 1'b1);
        rst_n = 1'b1;
        bus_op(32'h0003_0004, 1'b0, 8'h00);
        check("post_rst_cnt0", cpu_din, 8'h00);
        bus_op(32'h0000_0123, 1'b0, 8'h00);
        check("rst_write_discarded", cpu_din, 8'h5B);
        bus_op(32'h0003_0004, 1'b0, 8'h00);
        check("post_rst_cnt2", cpu_din, 8'h02);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
